vga_capture: RTL
================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA output port: samples vga_r/g/b, hsync, vsync, blank and vga_pixel_clock in the system clock domain.
- Reconstructs pixel coordinates and streams captured pixels through a small FIFO on a valid/ready interface.
- Checks line and frame geometry and keeps sticky error flags.
- Used as an in-system self-check of the video path and as a bench scoreboard front-end.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
VSYNC_ACTIVE_LOW, 1, 1 = vga_vsync asserted when low
FIFO_DEPTH, 16, pixel FIFO entries; power of 2, minimum 4

Ports:
clk  in  1  system clock; frequency at least 4x the pixel clock
reset  in  1  synchronous, active-high
vga_pixel_clock  in  1  pixel clock, sampled as data
vga_r  in  8  red
vga_g  in  8  green
vga_b  in  8  blue
vga_hsync  in  1  horizontal sync (carried through, not used for counting)
vga_vsync  in  1  vertical sync, polarity set by VSYNC_ACTIVE_LOW
vga_blank  in  1  1 = blanking interval, 0 = active pixel
pix_valid  out  1  FIFO head valid
pix_ready  in  1  consumer accepts head
pix_rgb  out  24  {r,g,b}
pix_x  out  10  pixel column
pix_y  out  10  pixel row
pix_sof  out  1  pixel is (0,0)
pix_eol  out  1  pixel x == H_ACTIVE-1
frame_count  out  16  vsync assertion edges since reset; wraps
overflow  out  1  sticky: pixel dropped because FIFO full
line_error  out  1  sticky: bad line length or out-of-range pixel
frame_error  out  1  sticky: line count at vsync != V_ACTIVE
clear_errors  in  1  clears all three sticky flags

Behaviour:
- One clock (clk). Reset is synchronous and active-high: the reset port is named reset and the clock port is named clk.
- Reset values: all outputs 0; FIFO empty; sync pipes 0; x_cnt = y_cnt = 0; state WAIT_VSYNC.
- Input sampling:
  - All VGA inputs pass through an identical 2-stage register pipe (s1, s2), plus an s3 stage on the pixel clock.
  - Pixel event (pe) fires when s3 = 1 and s2 = 0, i.e. a falling pixel-clock edge at mid-pixel. The pe cycle uses the s2 data values.
- vsync edge (ve): pe with vsync inactive on the previous pe and active on this pe. Polarity is applied before the edge compare.
- State WAIT_VSYNC:
  - Ignore pixels.
  - On ve: frame_count++, x_cnt = y_cnt = 0, go to CAPTURE.
- State CAPTURE, evaluated only on pe:
  - Active pixel (blank = 0):
    - If x_cnt < H_ACTIVE and y_cnt < V_ACTIVE: push {sof, eol, y_cnt, x_cnt, rgb}, then x_cnt++.
    - Otherwise: drop the pixel, set line_error, x_cnt saturates at 1023.
  - Active-to-blank transition (blank was 0 on the previous pe):
    - If x_cnt != H_ACTIVE, set line_error.
    - x_cnt = 0; y_cnt++ (saturating at 1023).
  - On ve:
    - If y_cnt != V_ACTIVE, set frame_error.
    - y_cnt = 0, x_cnt = 0, frame_count++.
    - ve takes priority over the pixel rules in the same pe.
- FIFO:
  - Push when pe-push and (not full, or a pop happens in the same cycle).
  - Otherwise the pixel is dropped and overflow is set.
  - Pop when pix_valid and pix_ready. Head outputs are held stable while pix_valid = 1 and pix_ready = 0.
  - Push-to-pix_valid latency is 1 cycle when the FIFO is empty. There is no combinational path from input to output.
- Sticky flags: clear_errors clears all three. A new error in the same cycle wins and the flag reads 1.
- Reset mid-frame: pipeline and FIFO are flushed and any queued pixels are lost. Capture restarts at the next vsync edge, so the first pixel delivered afterwards has sof = 1.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants H_ACTIVE = 640 and V_ACTIVE = 480;
  - the 10-bit coordinate width;
  - the 46-bit pixel-entry layout {sof, eol, y[9:0], x[9:0], rgb[23:0]};
  - state encoding WAIT_VSYNC = 0, CAPTURE = 1.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH): synchronous, registered outputs, with full/empty flags and simultaneous push/pop supported when full.

Test Plan:
- 640x480 timing model with pixel clock = clk/4, two frames, pix_ready = 1. Expect:
  - 0 pixels before the first vsync;
  - frame 2 delivers exactly 307200 pixels;
  - first pixel sof = 1 at (0,0); last pixel eol = 1 at (639,479);
  - frame_count = 2; all error flags 0.
- RGB pattern {x[7:0], y[7:0], 8'hA5} → every captured pix_rgb matches its pix_x/pix_y.
- pix_ready low for 20 active pixels with FIFO_DEPTH = 16 → overflow = 1, pixels x = 16..19 dropped. Then raise pix_ready → x = 0..15 delivered in order, holding stable while stalled.
- One line with 639 active pixels → line_error = 1 and frame_error = 0. Then pulse clear_errors → line_error = 0, and the next correct line leaves it 0.
- Frame with 479 lines → frame_error = 1 at the next vsync. A frame with 481 lines → line_error = 1, frame_error = 1, and row 480 is never emitted.
- Reset asserted at x = 300, y = 100 → pix_valid = 0 the next cycle and no pixels until the following vsync. The first pixel afterwards is (0,0) with sof = 1, and frame_count restarts from 0 to 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, pixel-entry layout and capture state encoding for vga_capture.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;
  localparam int RGB_W    = 24;

  // One queued pixel: {sof, eol, y, x, rgb}, 46 bits wide.
  typedef struct packed {
    logic               sof;
    logic               eol;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [RGB_W-1:0]   rgb;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    CAPTURE    = 1'b1
  } cap_state_e;

  // Coordinate increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == {COORD_W{1'b1}}) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_capture_sync_fifo.sv
// Synchronous FIFO; head data and flags come straight from registers, and a
// push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop_i & ~empty_q;
  assign do_push_s = push_i & (~full_q | do_pop_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and registered full/empty flags; reset flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT_C);
      empty_q <= (cnt_d == '0);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receive-side capture: oversamples the VGA port in the clk domain,
// rebuilds pixel coordinates, checks geometry and queues pixels to a consumer.
module vga_capture #(
  parameter int H_ACTIVE         = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE         = vga_pkg::V_ACTIVE,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_pixel_clock,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_blank,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [15:0] frame_count,
  output logic        overflow,
  output logic        line_error,
  output logic        frame_error,
  input  logic        clear_errors
);

  import vga_pkg::*;

  localparam logic [COORD_W-1:0] H_LIM_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_LAST_C = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LIM_C  = COORD_W'(V_ACTIVE);

  logic pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic [23:0] rgb_s1_q, rgb_s2_q;
  logic hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, bl_s1_q, bl_s2_q;
  logic hsync_unused_s;

  cap_state_e state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [15:0] fc_q, fc_d;
  logic vs_prev_q, vs_prev_d, bl_prev_q, bl_prev_d;
  logic ovf_q, ovf_d, line_err_q, line_err_d, frame_err_q, frame_err_d;

  logic pe_s, vs_act_s, ve_s;
  logic push_s, pop_s, drop_s, line_set_s, frame_set_s;
  logic fifo_full_s, fifo_empty_s;
  pix_entry_t entry_s, head_s;

  // Two-stage sampling of every VGA input, plus a third pixel-clock stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      {pclk_s1_q, pclk_s2_q, pclk_s3_q} <= 3'b000;
      {rgb_s1_q, rgb_s2_q}              <= 48'd0;
      {hs_s1_q, hs_s2_q}                <= 2'b00;
      {vs_s1_q, vs_s2_q}                <= 2'b00;
      {bl_s1_q, bl_s2_q}                <= 2'b00;
    end else begin
      pclk_s1_q <= vga_pixel_clock;
      pclk_s2_q <= pclk_s1_q;
      pclk_s3_q <= pclk_s2_q;
      rgb_s1_q  <= {vga_r, vga_g, vga_b};
      rgb_s2_q  <= rgb_s1_q;
      hs_s1_q   <= vga_hsync;
      hs_s2_q   <= hs_s1_q;
      vs_s1_q   <= vga_vsync;
      vs_s2_q   <= vs_s1_q;
      bl_s1_q   <= vga_blank;
      bl_s2_q   <= bl_s1_q;
    end
  end

  // hsync is sampled alongside the other inputs but line structure comes from blank.
  assign hsync_unused_s = hs_s2_q;

  // Falling pixel-clock edge lands mid-pixel, where the s2 data is stable.
  assign pe_s     = pclk_s3_q & ~pclk_s2_q;
  assign vs_act_s = VSYNC_ACTIVE_LOW ? ~vs_s2_q : vs_s2_q;
  assign ve_s     = pe_s & vs_act_s & ~vs_prev_q;

  assign pop_s  = ~fifo_empty_s & pix_ready;
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  // Capture FSM: coordinate tracking, push requests and geometry error detection.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    fc_d        = fc_q;
    vs_prev_d   = vs_prev_q;
    bl_prev_d   = bl_prev_q;
    push_s      = 1'b0;
    line_set_s  = 1'b0;
    frame_set_s = 1'b0;
    if (pe_s) begin
      vs_prev_d = vs_act_s;
      bl_prev_d = bl_s2_q;
      case (state_q)
        WAIT_VSYNC: begin
          if (ve_s) begin
            fc_d    = fc_q + 16'd1;
            x_d     = '0;
            y_d     = '0;
            state_d = CAPTURE;
          end else begin
            state_d = WAIT_VSYNC;
          end
        end
        CAPTURE: begin
          if (ve_s) begin
            frame_set_s = (y_q != V_LIM_C);
            x_d         = '0;
            y_d         = '0;
            fc_d        = fc_q + 16'd1;
          end else if (!bl_s2_q) begin
            if ((x_q < H_LIM_C) && (y_q < V_LIM_C)) begin
              push_s = 1'b1;
              x_d    = x_q + 10'd1;
            end else begin
              line_set_s = 1'b1;
              x_d        = sat_inc(x_q);
            end
          end else if (!bl_prev_q) begin
            line_set_s = (x_q != H_LIM_C);
            x_d        = '0;
            y_d        = sat_inc(y_q);
          end else begin
            x_d = x_q;
          end
        end
        default: state_d = WAIT_VSYNC;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sticky flags: clear_errors drops them, a coincident new error keeps them set.
  always_comb begin
    ovf_d       = (ovf_q & ~clear_errors) | drop_s;
    line_err_d  = (line_err_q & ~clear_errors) | line_set_s;
    frame_err_d = (frame_err_q & ~clear_errors) | frame_set_s;
  end

  // Entry built from the current coordinates and the s2 colour sample.
  always_comb begin
    entry_s.sof = (x_q == '0) && (y_q == '0);
    entry_s.eol = (x_q == H_LAST_C);
    entry_s.y   = y_q;
    entry_s.x   = x_q;
    entry_s.rgb = rgb_s2_q;
  end

  // Capture state, counters and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_VSYNC;
      x_q         <= '0;
      y_q         <= '0;
      fc_q        <= 16'd0;
      vs_prev_q   <= 1'b0;
      bl_prev_q   <= 1'b0;
      ovf_q       <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fc_q        <= fc_d;
      vs_prev_q   <= vs_prev_d;
      bl_prev_q   <= bl_prev_d;
      ovf_q       <= ovf_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .data_i  (entry_s),
    .pop_i   (pix_ready),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign pix_valid   = ~fifo_empty_s;
  assign pix_rgb     = head_s.rgb;
  assign pix_x       = head_s.x;
  assign pix_y       = head_s.y;
  assign pix_sof     = head_s.sof;
  assign pix_eol     = head_s.eol;
  assign frame_count = fc_q;
  assign overflow    = ovf_q;
  assign line_error  = line_err_q;
  assign frame_error = frame_err_q;

endmodule
